// File: rtl/block_nest_checker.sv
// Streaming begin/end + case/endcase nesting checker: one ASCII char per accepted cycle,
// keyword matcher FSM feeding a one-bit-per-level type stack with sticky error/overflow.
module block_nest_checker #(
    parameter int MAX_DEPTH = 8,
    parameter int DEPTH_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [7:0]         in,
    output logic               result,
    output logic [DEPTH_W-1:0] depth,
    output logic               error,
    output logic               overflow
);

    typedef enum logic [4:0] {
        S_IDLE, S_B, S_BE, S_BEG, S_BEGI, S_BEGIN,
        S_C, S_CA, S_CAS, S_CASE,
        S_E, S_EN, S_END, S_ENDC, S_ENDCA, S_ENDCAS, S_ENDCASE,
        S_SKIP
    } state_t;

    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(MAX_DEPTH);

    state_t                 state_q, state_d, letter_nxt;
    logic [DEPTH_W-1:0]     depth_q, depth_d;
    logic [MAX_DEPTH-1:0]   stack_q, stack_d;
    logic                   error_q, error_d;
    logic                   ovf_q, ovf_d;
    logic                   result_q, result_d;
    logic                   is_letter;
    logic [7:0]             up;
    logic                   top;

    assign is_letter = ((in >= 8'h41) && (in <= 8'h5A)) || ((in >= 8'h61) && (in <= 8'h7A));
    assign up        = in & 8'hDF;

    // Top of stack lives at index depth-1; a mux loop avoids index-width mismatch.
    always_comb begin
        top = 1'b0;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            if (DEPTH_W'(i + 1) == depth_q) top = stack_q[i];
        end
    end

    // Any letter that does not extend a keyword prefix falls into SKIP,
    // which also covers words longer than ENDCASE.
    always_comb begin
        letter_nxt = S_SKIP;
        case (state_q)
            S_IDLE: begin
                if (up == 8'h42)      letter_nxt = S_B;
                else if (up == 8'h43) letter_nxt = S_C;
                else if (up == 8'h45) letter_nxt = S_E;
            end
            S_B:      if (up == 8'h45) letter_nxt = S_BE;
            S_BE:     if (up == 8'h47) letter_nxt = S_BEG;
            S_BEG:    if (up == 8'h49) letter_nxt = S_BEGI;
            S_BEGI:   if (up == 8'h4E) letter_nxt = S_BEGIN;
            S_C:      if (up == 8'h41) letter_nxt = S_CA;
            S_CA:     if (up == 8'h53) letter_nxt = S_CAS;
            S_CAS:    if (up == 8'h45) letter_nxt = S_CASE;
            S_E:      if (up == 8'h4E) letter_nxt = S_EN;
            S_EN:     if (up == 8'h44) letter_nxt = S_END;
            S_END:    if (up == 8'h43) letter_nxt = S_ENDC;
            S_ENDC:   if (up == 8'h41) letter_nxt = S_ENDCA;
            S_ENDCA:  if (up == 8'h53) letter_nxt = S_ENDCAS;
            S_ENDCAS: if (up == 8'h45) letter_nxt = S_ENDCASE;
            default:  letter_nxt = S_SKIP;
        endcase
    end

    always_comb begin
        state_d = state_q;
        depth_d = depth_q;
        stack_d = stack_q;
        error_d = error_q;
        ovf_d   = ovf_q;
        if (in_valid) begin
            if (is_letter) begin
                state_d = letter_nxt;
            end else begin
                state_d = S_IDLE;
                if (state_q == S_BEGIN || state_q == S_CASE) begin
                    if (depth_q == DEPTH_MAX) begin
                        ovf_d   = 1'b1;
                        error_d = 1'b1;
                    end else begin
                        for (int i = 0; i < MAX_DEPTH; i++) begin
                            if (DEPTH_W'(i) == depth_q) stack_d[i] = (state_q == S_CASE);
                        end
                        depth_d = depth_q + 1'b1;
                    end
                end else if (state_q == S_END || state_q == S_ENDCASE) begin
                    if (depth_q != '0 && top == (state_q == S_ENDCASE))
                        depth_d = depth_q - 1'b1;
                    else
                        error_d = 1'b1;
                end
            end
        end
        result_d = (depth_d == '0) && !error_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            depth_q  <= '0;
            stack_q  <= '0;
            error_q  <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            depth_q  <= depth_d;
            stack_q  <= stack_d;
            error_q  <= error_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
        end
    end

    assign result   = result_q;
    assign depth    = depth_q;
    assign error    = error_q;
    assign overflow = ovf_q;

endmodule

// File: doc/block_nest_checker.md
# block_nest_checker

Streaming keyword-nesting checker that consumes one ASCII character per accepted cycle and tracks properly nested `begin`/`end` and `case`/`endcase` blocks. It is the parametrised successor of the single-pair begin/end checker. It adds an input-valid strobe, a second keyword pair with type-checked nesting through a bounded bit stack, a depth output, and sticky error and overflow flags. It sits behind the character source in the text-parsing path, and its flags are consumed by the checker's reporting logic.

## Interface
- MAX_DEPTH, 8: stack capacity, in nesting levels; legal range 1..255.
- DEPTH_W, 4: width of `depth`; must satisfy 2^DEPTH_W > MAX_DEPTH.
- clk  input  1  rising-edge clock; single clock domain.
- reset  input  1  synchronous, active-low reset.
- in_valid  input  1  `in` is accepted on a rising edge of clk when in_valid=1; ignored otherwise.
- in  input  8  ASCII character.
- result  output  1  1 when all committed words are balanced and no error has occurred.
- depth  output  DEPTH_W  current number of open blocks.
- error  output  1  sticky mismatch/underflow/overflow flag.
- overflow  output  1  sticky flag: a push was attempted with depth==MAX_DEPTH.

## Operation
- Letter: `in` in 'A'..'Z' or 'a'..'z'. Matching is case-insensitive, so "bEGiN" matches begin. Any other byte is a separator (space, digits, punctuation, NUL).
- Word: a maximal run of letters. A word is committed on the accepted cycle in which a separator arrives after at least one letter.
  - Consecutive separators commit nothing.
  - A pending word with no separator yet is never committed.
- Recognition: a committed word is a keyword only if it exactly equals BEGIN, END, CASE or ENDCASE.
  - Prefixes, extensions and embedded matches do nothing: "beginE", "aEND", "ende" and "endcas" are all non-keywords.
  - Once a word exceeds 7 letters it is latched as a non-keyword until the next separator.
- Stack: one bit per level (0 = begin, 1 = case). The top of stack is at index depth-1.
- Commit actions:
  - BEGIN: push 0.
  - CASE: push 1.
  - END: if depth>0 and top==0, pop; otherwise set error.
  - ENDCASE: if depth>0 and top==1, pop; otherwise set error.
  - Non-keyword: no action.
- Push at depth==MAX_DEPTH: no push; set overflow and error; depth is unchanged.
- A failed END/ENDCASE leaves depth and the stack unchanged.
- Once error is set, further commits still update depth and the stack normally. error and overflow remain 1 until reset.
- result = (depth==0) && !error. The pending, uncommitted word has no effect on result.
- Word-matcher FSM states:
  - IDLE: between words.
  - Per-keyword prefix states: B, BE, BEG, BEGI, BEGIN, C, CA, CAS, CASE, E, EN, END, ENDC, ENDCA, ENDCAS, ENDCASE.
  - SKIP: the word is already known to be a non-keyword.
- FSM transitions:
  - In any state, a letter that extends a keyword prefix goes to that prefix state.
  - Any other letter goes to SKIP.
  - A separator commits per the current state and returns to IDLE.

## Timing
- Reset (reset=0 at a rising edge): depth=0, stack cleared, FSM=IDLE, error=0, overflow=0, result=1. Reset wins over in_valid in the same cycle.
- Reset mid-word discards the pending word. The first letter after reset starts a new word.
- All outputs are registered. The effect of a separator accepted at edge N is visible on the outputs after edge N, with no further latency.
- A letter never changes result, depth, error or overflow.
- in_valid=0: FSM, stack and outputs hold indefinitely. A word may span idle cycles.
- in_valid may be asserted on every cycle, giving one character per cycle of throughput; there is no backpressure.
- Pop of the last level: depth becomes 0 and result returns to 1 on the same edge, provided error=0.

## Test plan
- Reset, then "begin end " one character per cycle → after the first space: depth=1, result=0. After the second space: depth=0, result=1, error=0.
- "BEGIN case ENDCASE End " → depth goes 1,2,1,0; result=1 at the end. Then "begin case end " → after "end": error=1, depth stays 2, result=0.
- "end " from reset → error=1, depth=0, result=0. A following "begin end " keeps result=0, since error is sticky.
- "beginE bEND ende endcas " → no commits take effect: depth=0, result=1, error=0.
- With MAX_DEPTH=2: "begin begin begin " → depth=2, overflow=1, error=1. Then "end end " → depth=0, result still 0.
- "beg" with in_valid toggled off for 5 cycles between 'g' and 'i', then "in " → depth=1. Then assert reset=0 mid-word "ca" → all outputs back to reset values, result=1. Then "se " → non-keyword, depth=0.
